// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch bus: instruction memory read port plus the decode-side valid/ready handshake.
// master = fetch controller, slave = memory/decode side.
interface ifu_fetch_ctrl_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) ();
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] isr;
  logic [PC_W-1:0]    isr_pc;
  logic               isr_valid;
  logic               isr_ready;

  modport master (
    output imem_addr, imem_rd, isr, isr_pc, isr_valid,
    input  imem_data, isr_ready
  );

  modport slave (
    input  imem_addr, imem_rd, isr, isr_pc, isr_valid,
    output imem_data, isr_ready
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues imem reads, buffers returns in a prefetch queue feeding decode.
// Issue-to-isr_valid is 2 cycles; issue is credit-limited by queue space; optional IFU_HALT_DETECT_EN.
module ifu_fetch_ctrl #(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 16,
  parameter int QDEPTH   = 4,
  parameter int RESET_PC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             br_valid,
  input  logic [PC_W-1:0]  br_target,
  ifu_fetch_ctrl_if.master bus,
  output logic             busy
`ifdef IFU_HALT_DETECT_EN
  , output logic           halted
`endif
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t             state, state_nx;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    inflight_pc;
  logic               inflight;
  logic [INSTR_W-1:0] q_dat [QDEPTH];
  logic [PC_W-1:0]    q_pc  [QDEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               pop, push, issue, credit_ok, halt_blk;

  assign pop  = bus.isr_valid && bus.isr_ready;
  // A branch in the cycle the read returns kills that response.
  assign push = inflight && !br_valid;

  // Space must remain for every read already in flight, counting this cycle's pop.
  assign credit_ok = (int'(count) - int'(pop) + int'(inflight) + 1) <= QDEPTH;

`ifdef IFU_HALT_DETECT_EN
  logic halt_flag;
  logic halt_hit;

  assign halt_hit = push && (bus.imem_data == {INSTR_W{1'b1}});
  assign halt_blk = halt_flag || halt_hit;
  assign halted   = halt_flag;

  always_ff @(posedge clk) begin
    if (reset || br_valid) begin
      halt_flag <= 1'b0;
    end else if (halt_hit) begin
      halt_flag <= 1'b1;
    end
  end
`else
  assign halt_blk = 1'b0;
`endif

  assign issue = (state == FETCH) && en && !br_valid && credit_ok && !halt_blk && !reset;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en && !halt_blk) state_nx = FETCH;
      FETCH:   if (!en || halt_blk) state_nx = IDLE;
      FLUSH:   state_nx = (en && !halt_blk) ? FETCH : IDLE;
      default: state_nx = IDLE;
    endcase
    if (br_valid) state_nx = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RST_PC;
      inflight    <= 1'b0;
      inflight_pc <= RST_PC;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      if (br_valid) begin
        pc     <= br_target;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (issue) pc <= pc + 1'b1;
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_dat[wr_ptr] <= bus.imem_data;
      q_pc[wr_ptr]  <= inflight_pc;
    end
  end

  assign bus.imem_rd   = issue;
  assign bus.imem_addr = pc;
  assign bus.isr_valid = (count != '0);
  assign bus.isr       = bus.isr_valid ? q_dat[rd_ptr] : '0;
  assign bus.isr_pc    = bus.isr_valid ? q_pc[rd_ptr]  : '0;
  assign busy          = (state == FETCH) || (state == FLUSH);
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: model says decode must see the sequential stream from the last reset/redirect.
module tb_ifu_fetch_ctrl;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int QDEPTH  = 4;
  localparam logic [PC_W-1:0] RST_PC = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] dat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             br_valid;
  logic [PC_W-1:0]  br_target;
  logic             busy;
`ifdef IFU_HALT_DETECT_EN
  logic             halted;
`endif

  ifu_fetch_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bif ();

  ifu_fetch_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .QDEPTH(QDEPTH), .RESET_PC(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .br_valid (br_valid),
    .br_target(br_target),
    .bus      (bif),
    .busy     (busy)
`ifdef IFU_HALT_DETECT_EN
    , .halted (halted)
`endif
  );

  always #5 clk = ~clk;

  logic [INSTR_W-1:0] mem [256];
  always @(posedge clk) if (bif.imem_rd) bif.imem_data <= mem[bif.imem_addr];

  int errors = 0, checks = 0, rd_cnt = 0, dlv_cnt = 0, cyc = 0, first_rd = -1;
  bit lat_arm = 1'b0, prev_reset = 1'b0, prev_br = 1'b0, prev_hold = 1'b0;
  logic [PC_W-1:0]    hold_pc, gen_pc;
  logic [INSTR_W-1:0] hold_dat;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic top_up();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.pc  = gen_pc;
      e.dat = mem[gen_pc];
      exp_q.push_back(e);
      gen_pc = gen_pc + 1'b1;
    end
  endtask

  task automatic refill(input logic [PC_W-1:0] start);
    exp_q.delete();
    gen_pc = start;
    top_up();
  endtask

  // Monitor: samples on the falling edge, inputs change 1ns after the rising edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      refill(RST_PC);
      prev_reset = 1'b1;
      prev_br    = 1'b0;
      prev_hold  = 1'b0;
      lat_arm    = 1'b1;
      first_rd   = -1;
    end else begin
      if (prev_reset)
        chk("reset_state", 64'({bif.isr_valid, bif.imem_rd, busy, bif.imem_addr, bif.isr, bif.isr_pc}),
            64'({3'b000, RST_PC, {INSTR_W{1'b0}}, {PC_W{1'b0}}}));
      if (prev_br) chk("valid_after_branch", 64'(bif.isr_valid), 64'd0);
      if (prev_hold) chk("hold_stable", 64'({bif.isr_valid, bif.isr_pc, bif.isr}), 64'({1'b1, hold_pc, hold_dat}));
      if (bif.imem_rd) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        chk("issue_gate", 64'({en, br_valid}), 64'(2'b10));
      end
      if (lat_arm && bif.isr_valid) begin
        chk("fetch_latency", 64'(cyc - first_rd), 64'd2);
        lat_arm = 1'b0;
      end
      if (bif.isr_valid && bif.isr_ready) begin
        dlv_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL isr_stream: actual=%0h with no expected entry", bif.isr);
        end else begin
          e = exp_q.pop_front();
          chk("isr_stream", 64'({bif.isr_pc, bif.isr}), 64'(e));
          top_up();
        end
      end
      prev_hold = bif.isr_valid && !bif.isr_ready && !br_valid;
      hold_pc   = bif.isr_pc;
      hold_dat  = bif.isr;
      if (br_valid) begin
        refill(br_target);
        lat_arm = 1'b0;
      end
      prev_br    = br_valid;
      prev_reset = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic branch(input logic [PC_W-1:0] tgt);
    br_valid  = 1'b1;
    br_target = tgt;
    tick(1);
    br_valid  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0;
    reset = 1'b1; en = 1'b0; br_valid = 1'b0; br_target = '0; bif.isr_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = INSTR_W'($urandom) & 16'h7FFF;
    mem[0] = 3; mem[1] = 7; mem[2] = 15; mem[3] = 31; mem[4] = 64; mem[5] = 128; mem[6] = 255;
    tick(2);
    reset = 1'b0;

    // Straight-line fetch
    d0 = dlv_cnt;
    en = 1'b1; bif.isr_ready = 1'b1;
    tick(12);
    chk("straight_count", 64'(dlv_cnt - d0 >= 7), 64'd1);

    // Backpressure: exactly four reads, pc parked at 4, head held at 3
    en = 1'b0; bif.isr_ready = 1'b0;
    do_reset();
    en = 1'b1;
    r0 = rd_cnt;
    tick(10);
    chk("bp_reads", 64'(rd_cnt - r0), 64'd4);
    chk("bp_pc", 64'(bif.imem_addr), 64'd4);
    chk("bp_head", 64'({bif.isr_valid, bif.isr}), 64'({1'b1, 16'd3}));
    bif.isr_ready = 1'b1;
    tick(10);

    // Branch with two queued entries and one read in flight
    en = 1'b0; bif.isr_ready = 1'b0;
    do_reset();
    en = 1'b1;
    tick(4);
    bif.isr_ready = 1'b1;
    branch(8'd5);
    tick(12);

    // Mid-run reset
    en = 1'b0;
    do_reset();
    en = 1'b1; bif.isr_ready = 1'b1;
    tick(4);
    do_reset();
    tick(12);

    // PC wrap
    branch(8'd255);
    tick(10);

`ifdef IFU_HALT_DETECT_EN
    en = 1'b0;
    mem[2] = 16'hFFFF;
    do_reset();
    d0 = dlv_cnt;
    en = 1'b1; bif.isr_ready = 1'b1;
    for (int i = 0; i < 20 && !halted; i++) tick(1);
    chk("halt_set", 64'(halted), 64'd1);
    r0 = rd_cnt;
    tick(8);
    chk("halt_no_issue", 64'(rd_cnt - r0), 64'd0);
    chk("halt_delivered", 64'(dlv_cnt - d0), 64'd3);
    mem[2] = 15;
    branch(8'd0);
    chk("halt_cleared", 64'(halted), 64'd0);
    tick(10);
    chk("halt_resume", 64'(rd_cnt > r0), 64'd1);
`endif

    // Randomized traffic
    d0 = dlv_cnt;
    for (int i = 0; i < 3000; i++) begin
      en            = ($urandom_range(0, 7) != 0);
      bif.isr_ready = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 299) == 0);
      br_valid      = !reset && ($urandom_range(0, 39) == 0);
      br_target     = PC_W'($urandom);
      tick(1);
    end
    reset = 1'b0; br_valid = 1'b0; en = 1'b1; bif.isr_ready = 1'b1;
    tick(20);
    chk("random_progress", 64'(dlv_cnt - d0 > 500), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
